// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Fixed-latency data memory responder with byte/halfword/word access and error checking.
module dmem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_fcn,
    input  logic [2:0]  req_typ,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        fcn_q, fcn_d;
    logic [2:0]  typ_q, typ_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic          err_typ, err_align, err_range, err;
    logic [31:0]   rd_word, rd_shift, ld_data;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          mem_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            fcn_q   <= 1'b0;
            typ_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            fcn_q   <= fcn_d;
            typ_q   <= typ_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        fcn_d   = fcn_q;
        typ_d   = typ_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    fcn_d  = req_fcn;
                    typ_d  = req_typ;
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request decode works on the captured copy so late input changes are ignored.
    always_comb begin
        widx      = addr_q[AW+1:2];
        err_typ   = (typ_q == 3'd0) || (typ_q == 3'd4) || (typ_q == 3'd7);
        err_align = (((typ_q == MT_H) || (typ_q == MT_HU)) && addr_q[0])
                  || ((typ_q == MT_W) && (addr_q[1:0] != 2'b00));
        err_range = addr_q[31:2] >= 30'(DEPTH_WORDS);
        err       = err_typ || err_align || err_range;
        rd_word   = err_range ? 32'd0 : mem_q[widx];
        rd_shift  = rd_word >> {addr_q[1:0], 3'b000};
        case (typ_q)
            MT_B:    ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            MT_BU:   ld_data = {24'd0, rd_shift[7:0]};
            MT_H:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            MT_HU:   ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
        case (typ_q)
            MT_B, MT_BU: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_data = {4{data_q[7:0]}};
            end
            MT_H, MT_HU: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{data_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = data_q;
            end
        endcase
        mem_we = (state_q == S_RESP) && fcn_q && !err;
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_err   = 1'b0;
        resp_data  = 32'd0;
        if (state_q == S_RESP) begin
            resp_err  = err;
            resp_data = (err || fcn_q) ? 32'd0 : ld_data;
        end
    end

    // Storage is deliberately not reset; an async reset drops state out of RESP, so no write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[widx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - Directed self-checking bench for dmem_responder.
module tb_dmem_responder;
    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_fcn, resp_valid, resp_err;
    logic [31:0] req_addr, req_data, resp_data;
    logic [2:0]  req_typ;
    logic        b_valid, b_ready, b_fcn, b_rvalid, b_rerr;
    logic [31:0] b_addr, b_data, b_rdata;
    logic [2:0]  b_typ;

    int tests = 0;
    int fails = 0;
    int quiet_bad = 0;
    int lat;
    logic [31:0] rdata;
    logic        rerr;
    logic [7:0]  rdy_vec, vld_vec;
    int          stray;

    dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .req_fcn(req_fcn), .req_typ(req_typ),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_addr(b_addr), .req_data(b_data),
        .req_fcn(b_fcn), .req_typ(b_typ),
        .resp_valid(b_rvalid), .resp_data(b_rdata), .resp_err(b_rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on u_dut; inputs are scrambled after the accept edge.
    task automatic do_req(input string tag, input logic fcn, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] o_data, output logic o_err, output int o_lat);
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_fcn   = fcn;
        req_typ   = typ;
        req_addr  = addr;
        req_data  = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_fcn   = ~fcn;
        req_typ   = 3'd0;
        req_addr  = 32'hFFFF_FFFF;
        req_data  = 32'hA5A5_A5A5;
        o_lat  = 0;
        o_data = 32'hX;
        o_err  = 1'bX;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                o_lat  = n;
                o_data = resp_data;
                o_err  = resp_err;
                break;
            end else if (resp_data !== 32'd0 || resp_err !== 1'b0) begin
                quiet_bad++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_fcn = 1'b0; req_typ = 3'd0; req_addr = 32'd0; req_data = 32'd0;
        b_valid = 1'b0; b_fcn = 1'b0; b_typ = 3'd3; b_addr = 32'd0; b_data = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);

        // Release mid-cycle so the store below is accepted on the very first edge.
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_req("st_w", 1'b1, 3'd3, 32'h10, 32'hDEADBEEF, rdata, rerr, lat);
        check("st_w_lat", lat, 3);
        check("st_w_data", rdata, 32'd0);
        check("st_w_err", {31'd0, rerr}, 32'd0);
        do_req("ld_w", 1'b0, 3'd3, 32'h10, 32'd0, rdata, rerr, lat);
        check("ld_w_lat", lat, 3);
        check("ld_w_data", rdata, 32'hDEADBEEF);
        check("ld_w_err", {31'd0, rerr}, 32'd0);

        do_req("ld_b", 1'b0, 3'd1, 32'h13, 32'd0, rdata, rerr, lat);
        check("ld_b_data", rdata, 32'hFFFFFFDE);
        do_req("ld_bu", 1'b0, 3'd5, 32'h13, 32'd0, rdata, rerr, lat);
        check("ld_bu_data", rdata, 32'h000000DE);
        do_req("ld_h", 1'b0, 3'd2, 32'h10, 32'd0, rdata, rerr, lat);
        check("ld_h_data", rdata, 32'hFFFFBEEF);
        do_req("ld_hu", 1'b0, 3'd6, 32'h12, 32'd0, rdata, rerr, lat);
        check("ld_hu_data", rdata, 32'h0000DEAD);

        do_req("st_b", 1'b1, 3'd1, 32'h11, 32'h0000AB55, rdata, rerr, lat);
        check("st_b_err", {31'd0, rerr}, 32'd0);
        do_req("ld_w2", 1'b0, 3'd3, 32'h10, 32'd0, rdata, rerr, lat);
        check("ld_w2_data", rdata, 32'hDEAD55EF);
        do_req("ld_b2", 1'b0, 3'd1, 32'h12, 32'd0, rdata, rerr, lat);
        check("ld_b2_data", rdata, 32'hFFFFFFAD);

        do_req("st_w_mis", 1'b1, 3'd3, 32'h12, 32'h11223344, rdata, rerr, lat);
        check("st_w_mis_err", {31'd0, rerr}, 32'd1);
        check("st_w_mis_data", rdata, 32'd0);
        do_req("ld_w3", 1'b0, 3'd3, 32'h10, 32'd0, rdata, rerr, lat);
        check("ld_w3_data", rdata, 32'hDEAD55EF);
        do_req("ld_h_mis", 1'b0, 3'd2, 32'h11, 32'd0, rdata, rerr, lat);
        check("ld_h_mis_err", {31'd0, rerr}, 32'd1);
        check("ld_h_mis_data", rdata, 32'd0);
        do_req("typ4", 1'b0, 3'd4, 32'h10, 32'd0, rdata, rerr, lat);
        check("typ4_err", {31'd0, rerr}, 32'd1);
        check("typ4_data", rdata, 32'd0);
        do_req("typ7", 1'b1, 3'd7, 32'h10, 32'hFFFFFFFF, rdata, rerr, lat);
        check("typ7_err", {31'd0, rerr}, 32'd1);
        do_req("range", 1'b0, 3'd3, 32'h4000, 32'd0, rdata, rerr, lat);
        check("range_err", {31'd0, rerr}, 32'd1);
        check("range_data", rdata, 32'd0);
        do_req("ld_w4", 1'b0, 3'd3, 32'h10, 32'd0, rdata, rerr, lat);
        check("ld_w4_data", rdata, 32'hDEAD55EF);

        do_req("st_w14", 1'b1, 3'd3, 32'h14, 32'h00000000, rdata, rerr, lat);
        do_req("st_h16", 1'b1, 3'd2, 32'h16, 32'hABCD1234, rdata, rerr, lat);
        check("st_h16_err", {31'd0, rerr}, 32'd0);
        do_req("ld_w14", 1'b0, 3'd3, 32'h14, 32'd0, rdata, rerr, lat);
        check("ld_w14_data", rdata, 32'h12340000);

        // Back-to-back requests on the zero-latency instance.
        @(negedge clk);
        b_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rdy_vec[k] = b_ready;
            vld_vec[k] = b_rvalid;
            @(negedge clk);
        end
        b_valid = 1'b0;
        check("bp_ready", {24'd0, rdy_vec}, 32'h55);
        check("bp_valid", {24'd0, vld_vec}, 32'hAA);

        // Abort a store by reset while it is waiting.
        @(negedge clk);
        req_valid = 1'b1; req_fcn = 1'b1; req_typ = 3'd3;
        req_addr = 32'h20; req_data = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        check("abort_noresp", stray, 0);
        do_req("ld_abort", 1'b0, 3'd3, 32'h20, 32'd0, rdata, rerr, lat);
        check("ld_abort_lat", lat, 3);
        tests++;
        assert (rdata !== 32'hCAFEF00D) else begin
            fails++;
            $error("FAIL ld_abort_data: observed %h expected not %h", rdata, 32'hCAFEF00D);
        end
        check("quiet_outputs", quiet_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
